vx_csr_access_unit: RTL and testbench
=====================================

// Module: vx_csr_access_unit
// PURPOSE
//  Initiator side of the core CSR read/write port. Sits in the SFU after dispatch and
//  executes CSRRW/CSRRS/CSRRC (register and immediate forms) per warp. It drives read and
//  write requests into the core CSR data block and returns the old CSR value to writeback,
//  per lane. The unit is a one-stage pipeline with a registered, back-pressurable response.
// PARAMETERS
//  INSTANCE_ID  ""            debug instance tag
//  CORE_ID      0             core index; used for the global thread id
//  NUM_LANES    `NUM_THREADS  lanes per request/response
// PORTS
//  clk            in   1                 clock
//  reset          in   1                 asynchronous, active-high reset
//  req_valid      in   1                 request valid
//  req_ready      out  1                 request accepted when valid&ready (fire)
//  req_uuid       in   UUID_WIDTH        instruction uuid
//  req_wid        in   NW_WIDTH          warp id
//  req_tmask      in   NUM_LANES         active lanes
//  req_op         in   2                 csr_op_t: 01=RW, 10=RS, 11=RC (00 = illegal, read-only)
//  req_addr       in   `VX_CSR_ADDR_BITS CSR address
//  req_use_imm    in   1                 1: operand = zero-extended req_imm
//  req_imm        in   5                 immediate operand (uimm)
//  req_rs1_zero   in   1                 rs1 index is x0 (suppresses RS/RC write)
//  req_rs1_data   in   NUM_LANES*XLEN    rs1 value per lane
//  req_rd         in   NR_BITS           destination register
//  req_wb         in   1                 writeback enable
//  read_enable    out  1                 = request fire
//  read_uuid/wid/addr  out  ...          = req_uuid / req_wid / req_addr
//  read_data_ro   in   XLEN              read-only CSR value (comb, same cycle)
//  read_data_rw   in   XLEN              read/write CSR value (comb, same cycle)
//  write_enable   out  1                 CSR write strobe
//  write_uuid/wid/addr out ...           = req_uuid / req_wid / req_addr
//  write_data     out  XLEN              new CSR value
//  rsp_valid      out  1                 response valid (registered)
//  rsp_ready      in   1                 downstream ready
//  rsp_uuid/wid/tmask/rd/wb  out  ...    registered copies of the request fields
//  rsp_data       out  NUM_LANES*XLEN    old CSR value per lane
// BEHAVIOUR
//  - Reset: rsp_valid=0 and the response payload=0. read_enable and write_enable are 0
//    whenever there is no fire, including during reset.
//  - req_ready = !rsp_valid || rsp_ready. Sustains 1 req/cycle; latency fire->rsp_valid is 1 cycle.
//  - On fire, read and write are issued in the same cycle. The CSR data block registers the
//    write, so rsp_data returns the pre-write value (RISC-V semantics). The next request
//    observes the new value.
//  - Operand opnd = use_imm ? XLEN'(imm) : rs1_data[first set lane of tmask]. If tmask=0,
//    use lane 0.
//  - old = read_data_ro | read_data_rw.
//  - write_data: RW -> opnd; RS -> old|opnd; RC -> old&~opnd.
//  - write_enable = fire & (op!=0) & !ro_addr & !(op in {RS,RC} & (use_imm ? imm==0 : rs1_zero)),
//    where ro_addr = (req_addr[11:10]==2'b11).
//    * A write to a read-only address is dropped silently; the read still completes.
//  - rsp_data per lane i:
//    * `VX_CSR_THREAD_ID: i.
//    * `VX_CSR_THREAD_ID_GLOBAL: (CORE_ID*`NUM_WARPS + wid)*NUM_LANES + i.
//    * All other addresses: old, broadcast to every lane.
//    * Lanes not in tmask: 0.
//  - Stall: while rsp_valid && !rsp_ready, the response holds stable, req_ready=0, and no
//    read or write is issued.
//  - Simultaneous rsp handshake and new fire: the response register reloads in the same cycle
//    (no bubble).
//  - Reset mid-operation: any pending response is discarded and no CSR write is replayed.
// STRUCTURE
//  - Shared package (VX_gpu_pkg): csr_op_t and its encodings, CSR_RO_ADDR_MASK, and the
//    THREAD_ID/THREAD_ID_GLOBAL address constants.
//  - Sub-module vx_csr_rsp_reg: a one-entry valid/ready pipeline register with async reset,
//    holding {uuid, wid, tmask, rd, wb, data}.
//  - Lane-select priority encoder and per-lane data mux: inline generate loops.
// TESTING
//  1. RW mscratch: old=0x0, rs1=0x1234 (tmask=0b0100) -> write_enable=1, write_data=0x1234,
//     rsp_data[2]=0x0. Repeat the request -> rsp_data[2]=0x1234.
//  2. RS with rs1_zero=1 on MCYCLE (ro addr 0xB00 is rw, use 0xC00 CYCLE): write_enable=0;
//     rsp_data equals read_data_ro on all active lanes.
//  3. RC imm=5'b00011 with old FCSR=0x07 -> write_data=0x04, rsp_data=0x07.
//     RS imm=0 -> write_enable=0.
//  4. THREAD_ID_GLOBAL with CORE_ID=1, NUM_WARPS=4, wid=2, NUM_LANES=4, tmask=0b1011 ->
//     rsp_data={27,0,25,24} (lane 3..0).
//  5. Back-pressure: hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0,
//     read_enable/write_enable=0, rsp stable. Raise rsp_ready -> the next request fires
//     in the same cycle.
//  6. Assert reset while rsp_valid=1 -> rsp_valid=0 immediately (async reset), with no
//     write_enable pulse after release.

Source files
------------

// File: rtl/vx_csr_access_unit_pkg.sv
// Shared CSR access types: op encodings, address constants and core sizing.
package vx_csr_access_unit_pkg;

  localparam int XLEN          = 32;
  localparam int NUM_THREADS   = 4;
  localparam int NUM_WARPS     = 4;
  localparam int NW_WIDTH      = 2;
  localparam int UUID_WIDTH    = 44;
  localparam int NR_BITS       = 5;
  localparam int CSR_ADDR_BITS = 12;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

  // Addresses with both top bits set are read-only in the RISC-V CSR map.
  localparam logic [CSR_ADDR_BITS-1:0] CSR_RO_ADDR_MASK     = 12'hC00;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_THREAD_ID        = 12'hCC0;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_THREAD_ID_GLOBAL = 12'hCC5;

  function automatic logic csr_is_ro(input logic [CSR_ADDR_BITS-1:0] addr);
    return (addr & CSR_RO_ADDR_MASK) == CSR_RO_ADDR_MASK;
  endfunction

endpackage

// File: rtl/vx_csr_access_unit_if.sv
// Request, CSR read/write and response bundle of the CSR access unit.
interface vx_csr_access_unit_if
  import vx_csr_access_unit_pkg::*;
#(
  parameter int NUM_LANES = NUM_THREADS
) ();

  logic                          req_valid;
  logic                          req_ready;
  logic [UUID_WIDTH-1:0]         req_uuid;
  logic [NW_WIDTH-1:0]           req_wid;
  logic [NUM_LANES-1:0]          req_tmask;
  csr_op_t                       req_op;
  logic [CSR_ADDR_BITS-1:0]      req_addr;
  logic                          req_use_imm;
  logic [4:0]                    req_imm;
  logic                          req_rs1_zero;
  logic [NUM_LANES*XLEN-1:0]     req_rs1_data;
  logic [NR_BITS-1:0]            req_rd;
  logic                          req_wb;

  logic                          read_enable;
  logic [UUID_WIDTH-1:0]         read_uuid;
  logic [NW_WIDTH-1:0]           read_wid;
  logic [CSR_ADDR_BITS-1:0]      read_addr;
  logic [XLEN-1:0]               read_data_ro;
  logic [XLEN-1:0]               read_data_rw;

  logic                          write_enable;
  logic [UUID_WIDTH-1:0]         write_uuid;
  logic [NW_WIDTH-1:0]           write_wid;
  logic [CSR_ADDR_BITS-1:0]      write_addr;
  logic [XLEN-1:0]               write_data;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [UUID_WIDTH-1:0]         rsp_uuid;
  logic [NW_WIDTH-1:0]           rsp_wid;
  logic [NUM_LANES-1:0]          rsp_tmask;
  logic [NR_BITS-1:0]            rsp_rd;
  logic                          rsp_wb;
  logic [NUM_LANES*XLEN-1:0]     rsp_data;

  // The access unit: consumes requests, drives the CSR port and the response.
  modport master (
    input  req_valid, req_uuid, req_wid, req_tmask, req_op, req_addr,
           req_use_imm, req_imm, req_rs1_zero, req_rs1_data, req_rd, req_wb,
    output req_ready,
    output read_enable, read_uuid, read_wid, read_addr,
    input  read_data_ro, read_data_rw,
    output write_enable, write_uuid, write_wid, write_addr, write_data,
    output rsp_valid, rsp_uuid, rsp_wid, rsp_tmask, rsp_rd, rsp_wb, rsp_data,
    input  rsp_ready
  );

  // The surroundings: dispatch, CSR data block and writeback.
  modport slave (
    output req_valid, req_uuid, req_wid, req_tmask, req_op, req_addr,
           req_use_imm, req_imm, req_rs1_zero, req_rs1_data, req_rd, req_wb,
    input  req_ready,
    input  read_enable, read_uuid, read_wid, read_addr,
    output read_data_ro, read_data_rw,
    input  write_enable, write_uuid, write_wid, write_addr, write_data,
    input  rsp_valid, rsp_uuid, rsp_wid, rsp_tmask, rsp_rd, rsp_wb, rsp_data,
    output rsp_ready
  );

endinterface

// File: rtl/vx_csr_access_unit_rsp_reg.sv
// One-entry valid/ready pipeline register; reloads on the same cycle it drains.
module vx_csr_access_unit_rsp_reg #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data
);

  logic             valid_d, valid_q;
  logic [DATAW-1:0] data_d, data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next-state: load on accept, otherwise hold the entry stable.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // State flops; async reset discards any pending entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/vx_csr_access_unit.sv
// CSR access unit: executes CSRRW/RS/RC per warp and returns the old value per lane.
module vx_csr_access_unit
  import vx_csr_access_unit_pkg::*;
#(
  parameter string INSTANCE_ID = "",
  parameter int    CORE_ID     = 0,
  parameter int    NUM_LANES   = NUM_THREADS
) (
  input  logic                clk,
  input  logic                reset,
  vx_csr_access_unit_if.master bus
);

  localparam int LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int RSP_DATAW = UUID_WIDTH + NW_WIDTH + NUM_LANES + NR_BITS + 1 + NUM_LANES * XLEN;
  localparam int WARP_BASE = CORE_ID * NUM_WARPS;

  logic                          rsp_in_ready_s;
  logic                          fire_s;
  logic [LANE_BITS-1:0]          sel_lane_s;
  logic [XLEN-1:0]               opnd_s;
  logic [XLEN-1:0]               old_s;
  logic [XLEN-1:0]               wdata_s;
  logic                          wr_suppress_s;
  logic [XLEN-1:0]               gid_base_s;
  logic [NUM_LANES-1:0][XLEN-1:0] lane_data_s;
  logic [RSP_DATAW-1:0]          rsp_payload_s;

  // Requests are never accepted while reset is held, so no CSR access leaks out.
  assign bus.req_ready = rsp_in_ready_s;
  assign fire_s        = bus.req_valid && rsp_in_ready_s && !reset;

  assign bus.read_enable = fire_s;
  assign bus.read_uuid   = bus.req_uuid;
  assign bus.read_wid    = bus.req_wid;
  assign bus.read_addr   = bus.req_addr;

  // Operand lane: lowest set bit of tmask, lane 0 when tmask is empty.
  always_comb begin
    sel_lane_s = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (bus.req_tmask[i]) begin
        sel_lane_s = LANE_BITS'(i);
      end else begin
        sel_lane_s = sel_lane_s;
      end
    end
  end

  assign opnd_s = bus.req_use_imm ? XLEN'(bus.req_imm)
                                  : bus.req_rs1_data[sel_lane_s * XLEN +: XLEN];
  assign old_s  = bus.read_data_ro | bus.read_data_rw;

  // New CSR value by operation; an illegal op rewrites nothing meaningful.
  always_comb begin
    case (bus.req_op)
      CSR_OP_RW: wdata_s = opnd_s;
      CSR_OP_RS: wdata_s = old_s | opnd_s;
      CSR_OP_RC: wdata_s = old_s & ~opnd_s;
      default:   wdata_s = old_s;
    endcase
  end

  // Set/clear with a zero operand source is a pure read and must not write.
  assign wr_suppress_s = ((bus.req_op == CSR_OP_RS) || (bus.req_op == CSR_OP_RC))
                      && (bus.req_use_imm ? (bus.req_imm == 5'd0) : bus.req_rs1_zero);

  assign bus.write_enable = fire_s && (bus.req_op != CSR_OP_NONE)
                         && !csr_is_ro(bus.req_addr) && !wr_suppress_s;
  assign bus.write_uuid   = bus.req_uuid;
  assign bus.write_wid    = bus.req_wid;
  assign bus.write_addr   = bus.req_addr;
  assign bus.write_data   = wdata_s;

  assign gid_base_s = XLEN'((WARP_BASE + int'(bus.req_wid)) * NUM_LANES);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_data_s[i] = !bus.req_tmask[i]                        ? XLEN'(0) :
                            (bus.req_addr == CSR_THREAD_ID)          ? XLEN'(i) :
                            (bus.req_addr == CSR_THREAD_ID_GLOBAL)   ? gid_base_s + XLEN'(i) :
                                                                       old_s;
  end

  vx_csr_access_unit_rsp_reg #(
    .DATAW (RSP_DATAW)
  ) u_rsp_reg (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (fire_s),
    .in_ready  (rsp_in_ready_s),
    .in_data   ({bus.req_uuid, bus.req_wid, bus.req_tmask, bus.req_rd, bus.req_wb, lane_data_s}),
    .out_valid (bus.rsp_valid),
    .out_ready (bus.rsp_ready),
    .out_data  (rsp_payload_s)
  );

  assign {bus.rsp_uuid, bus.rsp_wid, bus.rsp_tmask, bus.rsp_rd, bus.rsp_wb, bus.rsp_data} = rsp_payload_s;

endmodule

// File: tb/tb_vx_csr_access_unit.sv
// Directed bench for vx_csr_access_unit with a small CSR data block model.
module tb_vx_csr_access_unit;
  import vx_csr_access_unit_pkg::*;

  localparam int NL = 4;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  vx_csr_access_unit_if #(.NUM_LANES(NL)) bus ();

  vx_csr_access_unit #(
    .INSTANCE_ID ("tb"),
    .CORE_ID     (1),
    .NUM_LANES   (NL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // CSR data block model: mscratch (0x340) and fcsr (0x003) registered, CYCLE (0xC00) constant.
  logic [31:0] mscratch_m, fcsr_m;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mscratch_m <= 32'h0;
      fcsr_m     <= 32'h7;
    end else if (bus.write_enable) begin
      if (bus.write_addr == 12'h340) mscratch_m <= bus.write_data;
      if (bus.write_addr == 12'h003) fcsr_m <= bus.write_data;
    end
  end
  assign bus.read_data_rw = (bus.read_addr == 12'h340) ? mscratch_m :
                            (bus.read_addr == 12'h003) ? fcsr_m : 32'h0;
  assign bus.read_data_ro = (bus.read_addr == 12'hC00) ? 32'hABCD0001 : 32'h0;

  task automatic drive_req(input csr_op_t op, input logic [11:0] addr, input logic use_imm,
                           input logic [4:0] imm, input logic rs1_zero, input logic [127:0] rs1,
                           input logic [3:0] tmask, input logic [1:0] wid);
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_addr     = addr;
    bus.req_use_imm  = use_imm;
    bus.req_imm      = imm;
    bus.req_rs1_zero = rs1_zero;
    bus.req_rs1_data = rs1;
    bus.req_tmask    = tmask;
    bus.req_wid      = wid;
    bus.req_rd       = 5'd7;
    bus.req_wb       = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_uuid  = 44'h0;
    drive_req(CSR_OP_RW, 12'h340, 1'b0, 5'd0, 1'b0, {4{32'h0000_0099}}, 4'b1111, 2'd0);
    @(negedge clk); @(negedge clk);
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %0b want 0", bus.rsp_valid); end
    tests_run++; if (bus.rsp_data !== 128'h0) begin tests_failed++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
    tests_run++; if (bus.read_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_read_en: got %0b want 0", bus.read_enable); end
    tests_run++; if (bus.write_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_write_en: got %0b want 0", bus.write_enable); end
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %0b want 1", bus.req_ready); end
  endtask

  task automatic test_rw();
    @(negedge clk);
    drive_req(CSR_OP_RW, 12'h340, 1'b0, 5'd0, 1'b0,
              {32'h0000_0011, 32'h0000_1234, 32'h0000_0005, 32'h0000_DEAD}, 4'b0100, 2'd1);
    #1;
    tests_run++; if (bus.write_enable !== 1'b1) begin tests_failed++; $display("FAIL rw_we: got %0b want 1", bus.write_enable); end
    tests_run++; if (bus.write_data !== 32'h1234) begin tests_failed++; $display("FAIL rw_wdata: got %h want 1234", bus.write_data); end
    tests_run++; if (bus.read_enable !== 1'b1) begin tests_failed++; $display("FAIL rw_re: got %0b want 1", bus.read_enable); end
    @(posedge clk); #1;
    tests_run++; if (bus.rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL rw_rsp_valid: got %0b want 1", bus.rsp_valid); end
    tests_run++; if (bus.rsp_data !== 128'h0) begin tests_failed++; $display("FAIL rw_rsp_old: got %h want 0", bus.rsp_data); end
    tests_run++; if (bus.rsp_tmask !== 4'b0100 || bus.rsp_wid !== 2'd1) begin tests_failed++; $display("FAIL rw_rsp_fields: got %b/%0d want 0100/1", bus.rsp_tmask, bus.rsp_wid); end
    // request held: fires again and sees the value written a cycle earlier
    @(posedge clk); #1;
    tests_run++; if (bus.rsp_data[95:64] !== 32'h1234) begin tests_failed++; $display("FAIL rw_repeat: got %h want 1234", bus.rsp_data[95:64]); end
    // empty tmask: operand from lane 0, response all zero
    @(negedge clk);
    drive_req(CSR_OP_RW, 12'h340, 1'b0, 5'd0, 1'b0,
              {32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_00AA}, 4'b0000, 2'd0);
    #1;
    tests_run++; if (bus.write_data !== 32'hAA) begin tests_failed++; $display("FAIL rw_tmask0_wdata: got %h want aa", bus.write_data); end
    @(posedge clk); #1;
    tests_run++; if (bus.rsp_data !== 128'h0) begin tests_failed++; $display("FAIL rw_tmask0_rsp: got %h want 0", bus.rsp_data); end
    @(negedge clk); bus.req_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_drain: got %0b want 0", bus.rsp_valid); end
  endtask

  task automatic test_rs_ro();
    logic [31:0] exp [NL];
    @(negedge clk);
    drive_req(CSR_OP_RS, 12'hC00, 1'b0, 5'd0, 1'b1, {4{32'hFFFF_FFFF}}, 4'b1101, 2'd3);
    bus.req_uuid = 44'h0ABC;
    bus.req_rd   = 5'd9;
    #1;
    tests_run++; if (bus.write_enable !== 1'b0) begin tests_failed++; $display("FAIL rs_ro_we: got %0b want 0", bus.write_enable); end
    tests_run++; if (bus.read_enable !== 1'b1 || bus.read_addr !== 12'hC00) begin tests_failed++; $display("FAIL rs_ro_read: got %0b/%h want 1/c00", bus.read_enable, bus.read_addr); end
    @(posedge clk); #1;
    exp = '{32'hABCD0001, 32'h0, 32'hABCD0001, 32'hABCD0001};
    for (int i = 0; i < NL; i++) begin
      tests_run++; if (bus.rsp_data[i*32 +: 32] !== exp[i]) begin tests_failed++; $display("FAIL rs_ro_lane%0d: got %h want %h", i, bus.rsp_data[i*32 +: 32], exp[i]); end
    end
    tests_run++; if (bus.rsp_uuid !== 44'h0ABC || bus.rsp_rd !== 5'd9 || bus.rsp_wb !== 1'b1) begin tests_failed++; $display("FAIL rs_ro_fields: got %h/%0d/%0b want abc/9/1", bus.rsp_uuid, bus.rsp_rd, bus.rsp_wb); end
    @(negedge clk); bus.req_valid = 1'b0;
  endtask

  task automatic test_rc_imm();
    @(negedge clk);
    drive_req(CSR_OP_RC, 12'h003, 1'b1, 5'b00011, 1'b0, 128'h0, 4'b0001, 2'd0);
    #1;
    tests_run++; if (bus.write_enable !== 1'b1 || bus.write_data !== 32'h4) begin tests_failed++; $display("FAIL rc_imm_write: got %0b/%h want 1/4", bus.write_enable, bus.write_data); end
    @(posedge clk); #1;
    tests_run++; if (bus.rsp_data[31:0] !== 32'h7) begin tests_failed++; $display("FAIL rc_imm_old: got %h want 7", bus.rsp_data[31:0]); end
    @(negedge clk);
    drive_req(CSR_OP_RS, 12'h003, 1'b1, 5'd0, 1'b0, 128'h0, 4'b0001, 2'd0);
    #1;
    tests_run++; if (bus.write_enable !== 1'b0) begin tests_failed++; $display("FAIL rs_imm0_we: got %0b want 0", bus.write_enable); end
    @(posedge clk); #1;
    tests_run++; if (bus.rsp_data[31:0] !== 32'h4) begin tests_failed++; $display("FAIL rs_imm0_old: got %h want 4", bus.rsp_data[31:0]); end
    // immediate form ignores rs1_zero
    @(negedge clk);
    drive_req(CSR_OP_RS, 12'h003, 1'b1, 5'd8, 1'b1, 128'h0, 4'b0001, 2'd0);
    #1;
    tests_run++; if (bus.write_enable !== 1'b1 || bus.write_data !== 32'hC) begin tests_failed++; $display("FAIL rs_imm8_write: got %0b/%h want 1/c", bus.write_enable, bus.write_data); end
    @(negedge clk);
    drive_req(CSR_OP_NONE, 12'h003, 1'b0, 5'd0, 1'b0, {4{32'h0000_00FF}}, 4'b0001, 2'd0);
    #1;
    tests_run++; if (bus.write_enable !== 1'b0) begin tests_failed++; $display("FAIL op_none_we: got %0b want 0", bus.write_enable); end
    @(posedge clk); #1;
    tests_run++; if (bus.rsp_data[31:0] !== 32'hC) begin tests_failed++; $display("FAIL op_none_old: got %h want c", bus.rsp_data[31:0]); end
    @(negedge clk); bus.req_valid = 1'b0;
  endtask

  task automatic test_thread_id();
    logic [31:0] exp [NL];
    @(negedge clk);
    drive_req(CSR_OP_NONE, 12'hCC5, 1'b0, 5'd0, 1'b1, 128'h0, 4'b1011, 2'd2);
    @(posedge clk); #1;
    exp = '{32'd24, 32'd25, 32'd0, 32'd27};
    for (int i = 0; i < NL; i++) begin
      tests_run++; if (bus.rsp_data[i*32 +: 32] !== exp[i]) begin tests_failed++; $display("FAIL tid_global_lane%0d: got %0d want %0d", i, bus.rsp_data[i*32 +: 32], exp[i]); end
    end
    @(negedge clk);
    drive_req(CSR_OP_RS, 12'hCC0, 1'b0, 5'd0, 1'b1, 128'h0, 4'b1111, 2'd0);
    @(posedge clk); #1;
    for (int i = 0; i < NL; i++) begin
      tests_run++; if (bus.rsp_data[i*32 +: 32] !== 32'(i)) begin tests_failed++; $display("FAIL tid_lane%0d: got %0d want %0d", i, bus.rsp_data[i*32 +: 32], i); end
    end
    @(negedge clk); bus.req_valid = 1'b0;
  endtask

  task automatic test_back_pressure();
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive_req(CSR_OP_RW, 12'h340, 1'b0, 5'd0, 1'b0, {96'h0, 32'h0000_0055}, 4'b0001, 2'd0);
    @(posedge clk); #1;
    tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data[31:0] !== 32'hAA) begin tests_failed++; $display("FAIL bp_first: got %0b/%h want 1/aa", bus.rsp_valid, bus.rsp_data[31:0]); end
    @(negedge clk);
    drive_req(CSR_OP_RW, 12'h340, 1'b0, 5'd0, 1'b0, {96'h0, 32'h0000_0066}, 4'b0001, 2'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++; if (bus.req_ready !== 1'b0 || bus.read_enable !== 1'b0 || bus.write_enable !== 1'b0) begin tests_failed++; $display("FAIL bp_stall%0d: got rdy/re/we %0b%0b%0b want 000", c, bus.req_ready, bus.read_enable, bus.write_enable); end
      tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data[31:0] !== 32'hAA) begin tests_failed++; $display("FAIL bp_hold%0d: got %0b/%h want 1/aa", c, bus.rsp_valid, bus.rsp_data[31:0]); end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    tests_run++; if (bus.req_ready !== 1'b1 || bus.write_enable !== 1'b1 || bus.write_data !== 32'h66) begin tests_failed++; $display("FAIL bp_release: got %0b/%0b/%h want 1/1/66", bus.req_ready, bus.write_enable, bus.write_data); end
    @(posedge clk); #1;
    tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data[31:0] !== 32'h55) begin tests_failed++; $display("FAIL bp_reload: got %0b/%h want 1/55", bus.rsp_valid, bus.rsp_data[31:0]); end
    @(negedge clk); bus.req_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain: got %0b want 0", bus.rsp_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive_req(CSR_OP_RW, 12'h340, 1'b0, 5'd0, 1'b0, {96'h0, 32'h0000_0077}, 4'b0001, 2'd0);
    @(posedge clk); #1;
    tests_run++; if (bus.rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pending: got %0b want 1", bus.rsp_valid); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 128'h0) begin tests_failed++; $display("FAIL rstmid_async: got %0b/%h want 0/0", bus.rsp_valid, bus.rsp_data); end
    tests_run++; if (bus.write_enable !== 1'b0 || bus.read_enable !== 1'b0) begin tests_failed++; $display("FAIL rstmid_strobes: got %0b/%0b want 0/0", bus.write_enable, bus.read_enable); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++; if (bus.write_enable !== 1'b0 || bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_after%0d: got we/valid %0b/%0b want 0/0", c, bus.write_enable, bus.rsp_valid); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_rs_ro();
    test_rc_imm();
    test_thread_id();
    test_back_pressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
